// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-add cell (two half adders + OR)
// processes one operand bit pair per clock, LSB first, behind a start/busy/done handshake.

module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, part;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             ha0_s, ha0_c, ha1_c, s, carry_nx, last;

  half_add u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_add u_ha1 (.x(ha0_s),   .y(carry),   .s(s),     .c(ha1_c));

  assign carry_nx = ha0_c | ha1_c;
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so every output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_nx;
          part  <= {s, part[WIDTH-1:1]};
          // counter parks on the last bit so it never wraps for power-of-two widths
          if (!last) cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= {s, part[WIDTH-1:1]};
            cout <= carry_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver predicts results with plain addition,
// monitor pops and compares whenever the DUT raises done.

module tb_serial_add_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout, busy, done;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [W:0]   q[$];
  logic [W:0]   hold = '0;
  // cycles left until the block is idle again: W+1 after accept, busy while >=2, done at 1
  int           rem = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      rem = 0;
      q.delete();
    end else if (rem == 0) begin
      if (start) begin
        q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
        rem = W + 1;
      end
    end else begin
      rem--;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(W + 1);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) hold = '0;
      chk("busy", 64'(busy), 64'(rem >= 2));
      chk("done", 64'(done), 64'(rem == 1));
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          hold = q.pop_front();
        end
      end
      chk("sum", 64'(sum), 64'(hold[W-1:0]));
      chk("cout", 64'(cout), 64'(hold[W]));
    end
  end

  // Driver
  initial begin
    ticks(2);
    rst = 1'b0;
    ticks(5);

    run_op(8'h5A, 8'h3C, 1'b0);
    ticks(2);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);

    // start pulses while RUN and while DONE must be ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(3);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);

    // asynchronous reset mid-operation
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    #2;
    rst = 1'b1;
    rem = 0;
    q.delete();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    ticks(2);
    rst = 1'b0;
    ticks(W + 4);

    // back-to-back with start held high, operands changed after acceptance
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'hEE; b = 8'hEE;
    ticks(2 * (W + 2) - 1);
    start = 1'b0;
    ticks(W + 3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      tick();
    end
    start = 1'b0;
    ticks(W + 3);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1);
  end
endmodule
